mem_responder: RTL and testbench

//  Memory-side responder for the CPU memory interface driven by the control FSM (mem_cmd/mem_addr/write_data).

---
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: services one MREAD/MWRITE at a time against a RAM or
// memory-mapped LED/switch registers, then pulses mem_ready for one cycle.
module mem_responder #(
  parameter int                 DATA_W      = 16,
  parameter int                 ADDR_W      = 9,
  parameter int                 RAM_WORDS   = 256,
  parameter int                 WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0]  LED_ADDR    = 9'h100,
  parameter logic [ADDR_W-1:0]  SW_ADDR     = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [7:0]        sw,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              bad_access,
  output logic [7:0]        ledr
);

  localparam int         RAM_AW = $clog2(RAM_WORDS);
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  // Handshake: the initiator holds mem_cmd (anything but MNONE) until the
  // one-cycle mem_ready pulse, then drives MNONE or a new command.
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_next;
  logic [3:0]          cnt, cnt_next;
  logic [1:0]          cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                bad_q;

  logic [DATA_W-1:0]   ram [RAM_WORDS];

  logic [1:0]          eff_cmd;
  logic [ADDR_W-1:0]   eff_addr;
  logic [DATA_W-1:0]   eff_data;
  logic [RAM_AW-1:0]   ram_idx;
  logic                capture;
  logic                commit;
  logic                is_io;
  logic                ok_ram_wr, ok_led_wr, ok_ram_rd, ok_sw_rd;
  logic                ram_wr, led_wr, ram_rd, sw_rd, bad_now, bad_rd;

  // With zero wait states the commit edge is the capture edge, so the live
  // inputs are used in IDLE and the latched copies everywhere else.
  always_comb begin
    eff_cmd  = cmd_q;
    eff_addr = addr_q;
    eff_data = data_q;
    if (state == IDLE) begin
      eff_cmd  = mem_cmd;
      eff_addr = mem_addr;
      eff_data = write_data;
    end
  end

  assign capture = (state == IDLE) && (mem_cmd != MNONE);
  assign commit  = !reset &&
                   ((capture && (WS == 4'd0)) || ((state == BUSY) && (cnt == 4'd1)));

  assign ram_idx   = eff_addr[RAM_AW-1:0];
  assign is_io     = eff_addr[ADDR_W-1];
  assign ok_ram_wr = (eff_cmd == MWRITE) && !is_io;
  assign ok_led_wr = (eff_cmd == MWRITE) && (eff_addr == LED_ADDR);
  assign ok_ram_rd = (eff_cmd == MREAD) && !is_io;
  assign ok_sw_rd  = (eff_cmd == MREAD) && (eff_addr == SW_ADDR);

  assign ram_wr  = commit && ok_ram_wr;
  assign led_wr  = commit && ok_led_wr;
  assign ram_rd  = commit && ok_ram_rd;
  assign sw_rd   = commit && ok_sw_rd;
  assign bad_now = commit && !(ok_ram_wr || ok_led_wr || ok_ram_rd || ok_sw_rd);
  assign bad_rd  = bad_now && (eff_cmd == MREAD);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (capture) begin
          cnt_next   = WS;
          state_next = (WS == 4'd0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cmd_q     <= MNONE;
      addr_q    <= '0;
      data_q    <= '0;
      bad_q     <= 1'b0;
      read_data <= '0;
      ledr      <= 8'h00;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        cmd_q  <= mem_cmd;
        addr_q <= mem_addr;
        data_q <= write_data;
      end
      if (commit) bad_q <= bad_now;
      if (led_wr) ledr <= eff_data[7:0];
      if (ram_rd)
        read_data <= ram[ram_idx];
      else if (sw_rd)
        read_data <= {{(DATA_W-8){1'b0}}, sw};
      else if (bad_rd)
        read_data <= '0;
    end
  end

  // RAM is never cleared; ram_wr already excludes the reset cycle.
  always_ff @(posedge clk) begin
    if (ram_wr) ram[ram_idx] <= eff_data;
  end

  assign mem_ready  = (state == DONE);
  assign bad_access = (state == DONE) && bad_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (0, 1 and 4 wait states) checked
// against a behavioural memory/IO model with randomized transactions.
module tb_mem_responder;

  logic              clk;
  logic [2:0]        rst;
  logic [2:0][1:0]   cmd;
  logic [2:0][8:0]   addr;
  logic [2:0][15:0]  wdata;
  logic [2:0][7:0]   sw;
  wire  [2:0][15:0]  rdata;
  wire  [2:0]        rdy;
  wire  [2:0]        bad;
  wire  [2:0][7:0]   led;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_ram [3][256];
  logic [15:0] m_rd  [3];
  logic [7:0]  m_led [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(.WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 4))) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .mem_cmd   (cmd[g]),
      .mem_addr  (addr[g]),
      .write_data(wdata[g]),
      .sw        (sw[g]),
      .read_data (rdata[g]),
      .mem_ready (rdy[g]),
      .bad_access(bad[g]),
      .ledr      (led[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 4);
  endfunction

  // One complete transaction; the model result is computed up front from the
  // command's meaning, then latency, data, flags and pulse width are checked.
  task automatic txn(input int d, input logic [1:0] c, input logic [8:0] a,
                     input logic [15:0] wd, input bit scramble);
    logic [15:0] exp_rd;
    logic [7:0]  exp_led;
    logic        exp_bad;
    int          lat;
    exp_rd  = m_rd[d];
    exp_led = m_led[d];
    exp_bad = 1'b0;
    case (c)
      2'b10: begin
        if (!a[8])            m_ram[d][a[7:0]] = wd;
        else if (a == 9'h100) exp_led = wd[7:0];
        else                  exp_bad = 1'b1;
      end
      2'b01: begin
        if (!a[8])            exp_rd = m_ram[d][a[7:0]];
        else if (a == 9'h140) exp_rd = {8'h00, sw[d]};
        else begin
          exp_rd  = 16'h0000;
          exp_bad = 1'b1;
        end
      end
      default: exp_bad = 1'b1;
    endcase
    cmd[d]   = c;
    addr[d]  = a;
    wdata[d] = wd;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rdy[d]) begin
        lat = i;
        break;
      end
      if (scramble && i == 1) begin
        addr[d]  = 9'($urandom);
        wdata[d] = 16'($urandom);
      end
    end
    n_cmp++;
    if (lat !== ws_of(d) + 1) begin
      n_err++;
      $display("FAIL latency dut%0d cmd=%b addr=%h: got %0d cycles want %0d", d, c, a, lat, ws_of(d) + 1);
    end
    n_cmp++;
    if (rdata[d] !== exp_rd) begin
      n_err++;
      $display("FAIL read_data dut%0d cmd=%b addr=%h: got %h want %h", d, c, a, rdata[d], exp_rd);
    end
    n_cmp++;
    if (bad[d] !== exp_bad) begin
      n_err++;
      $display("FAIL bad_access dut%0d cmd=%b addr=%h: got %b want %b", d, c, a, bad[d], exp_bad);
    end
    n_cmp++;
    if (led[d] !== exp_led) begin
      n_err++;
      $display("FAIL ledr dut%0d cmd=%b addr=%h: got %h want %h", d, c, a, led[d], exp_led);
    end
    @(posedge clk); #1;
    cmd[d] = 2'b00;
    n_cmp++;
    if (rdy[d] !== 1'b0 || bad[d] !== 1'b0) begin
      n_err++;
      $display("FAIL pulse_width dut%0d: got ready=%b bad=%b want 0 0", d, rdy[d], bad[d]);
    end
    m_rd[d]  = exp_rd;
    m_led[d] = exp_led;
  endtask

  task automatic test_reset();
    rst = 3'b111;
    cmd = '0; addr = '0; wdata = '0; sw = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (rdata[d] !== 16'h0 || rdy[d] !== 1'b0 || bad[d] !== 1'b0 || led[d] !== 8'h0) begin
        n_err++;
        $display("FAIL reset_state dut%0d: got rd=%h rdy=%b bad=%b led=%h want all 0", d, rdata[d], rdy[d], bad[d], led[d]);
      end
      m_rd[d]  = 16'h0;
      m_led[d] = 8'h0;
    end
    rst = 3'b000;
    @(posedge clk); #1;
  endtask

  task automatic test_init_ram();
    for (int d = 0; d < 3; d++)
      for (int a = 0; a < 32; a++)
        txn(d, 2'b10, 9'(a), 16'($urandom), 1'b0);
  endtask

  task automatic test_ram_rw();
    for (int d = 0; d < 3; d++) begin
      txn(d, 2'b10, 9'h005, 16'hABCD, 1'b0);
      txn(d, 2'b01, 9'h005, 16'h0000, 1'b0);
    end
  endtask

  task automatic test_io();
    for (int d = 0; d < 3; d++) begin
      txn(d, 2'b10, 9'h100, 16'h12A5, 1'b0);
      sw[d] = 8'h3C;
      txn(d, 2'b01, 9'h140, 16'h0000, 1'b0);
    end
  endtask

  task automatic test_bad_access();
    for (int d = 0; d < 3; d++) begin
      txn(d, 2'b01, 9'h1F0, 16'h0000, 1'b0);
      txn(d, 2'b11, 9'h005, 16'h5555, 1'b0);
      txn(d, 2'b11, 9'h100, 16'h5555, 1'b0);
      txn(d, 2'b10, 9'h140, 16'h7777, 1'b0);
      txn(d, 2'b01, 9'h100, 16'h0000, 1'b0);
      txn(d, 2'b10, 9'h1F0, 16'h9999, 1'b0);
      txn(d, 2'b01, 9'h005, 16'h0000, 1'b0);
    end
  endtask

  task automatic test_busy_change();
    for (int d = 1; d < 3; d++) begin
      txn(d, 2'b10, 9'h007, 16'h0F0F, 1'b1);
      txn(d, 2'b01, 9'h007, 16'h0000, 1'b1);
      txn(d, 2'b10, 9'h100, 16'h00C3, 1'b1);
    end
  endtask

  task automatic test_reset_abort();
    for (int d = 1; d < 3; d++) begin
      txn(d, 2'b10, 9'h010, 16'h1111, 1'b0);
      cmd[d]   = 2'b10;
      addr[d]  = 9'h010;
      wdata[d] = 16'h2222;
      @(posedge clk); #1;
      rst[d] = 1'b1;
      cmd[d] = 2'b00;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        n_cmp++;
        if (rdy[d] !== 1'b0 || rdata[d] !== 16'h0 || bad[d] !== 1'b0 || led[d] !== 8'h0) begin
          n_err++;
          $display("FAIL abort_outputs dut%0d: got rdy=%b rd=%h bad=%b led=%h want all 0", d, rdy[d], rdata[d], bad[d], led[d]);
        end
      end
      rst[d] = 1'b0;
      m_rd[d]  = 16'h0;
      m_led[d] = 8'h0;
      @(posedge clk); #1;
      txn(d, 2'b01, 9'h010, 16'h0000, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++) begin
        txn(d, 2'b10, 9'(20 + k), 16'($urandom), 1'b0);
        txn(d, 2'b01, 9'(20 + k), 16'h0000, 1'b0);
      end
  endtask

  task automatic test_random();
    logic [1:0]  c;
    logic [8:0]  a;
    int          r;
    for (int n = 0; n < 150; n++) begin
      int d;
      d = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      c = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      if (r <= 5)      a = 9'($urandom_range(0, 31));
      else if (r == 6) a = 9'h100;
      else if (r == 7) a = 9'h140;
      else             a = {1'b1, 8'($urandom)};
      if (r == 9) c = 2'b11;
      sw[d] = 8'($urandom);
      txn(d, c, a, 16'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_init_ram();
    test_ram_rw();
    test_io();
    test_bad_access();
    test_busy_change();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
